// File: rtl/mram_fault_responder_pkg.sv
// mram_resp_pkg: shared types and fault-model functions for the MRAM MBIST responder.
// Rev 1.0 - initial release
`default_nettype none

package mram_resp_pkg;

    // The fault helpers work on a fixed 64-bit word; the instantiating logic zero-extends
    // and truncates, so DATA_W up to 64 is supported.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_BIT_W  = 6;

    typedef logic [MAX_DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FT_SA0  = 2'd0,
        FT_SA1  = 2'd1,
        FT_TFUP = 2'd2,
        FT_TFDN = 2'd3
    } fault_type_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WBUSY = 1'b1
    } state_e;

    function automatic word_t apply_write_fault(word_t old_w, word_t new_w,
                                                fault_type_e ft, logic [MAX_BIT_W-1:0] bit_idx);
        word_t res;
        res = new_w;
        case (ft)
            FT_SA0:  res[bit_idx] = 1'b0;
            FT_SA1:  res[bit_idx] = 1'b1;
            FT_TFUP: if (!old_w[bit_idx] && new_w[bit_idx]) res[bit_idx] = 1'b0;
            FT_TFDN: if (old_w[bit_idx] && !new_w[bit_idx]) res[bit_idx] = 1'b1;
            default: res = new_w;
        endcase
        return res;
    endfunction

    // Transition faults only corrupt stored state, so reads see them through the array.
    function automatic word_t apply_read_fault(word_t data, fault_type_e ft,
                                               logic [MAX_BIT_W-1:0] bit_idx);
        word_t res;
        res = data;
        case (ft)
            FT_SA0:  res[bit_idx] = 1'b0;
            FT_SA1:  res[bit_idx] = 1'b1;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mram_fault_responder_if.sv
// mram_fault_responder_if: MBIST test-port bus between controller (master) and responder (slave).
// Rev 1.0 - initial release
`default_nettype none

interface mram_fault_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              test_CEB;
    logic              test_WEB;
    logic [ADDR_W-1:0] test_A1;
    logic [DATA_W-1:0] test_DIN;
    logic [DATA_W-1:0] test_DOUT;
    logic              WRC;
    logic              cmd_drop;

    modport master (
        output test_CEB, test_WEB, test_A1, test_DIN,
        input  test_DOUT, WRC, cmd_drop
    );

    modport slave (
        input  test_CEB, test_WEB, test_A1, test_DIN,
        output test_DOUT, WRC, cmd_drop
    );
endinterface

`default_nettype wire

// File: rtl/mram_resp_array.sv
// mram_resp_array: DEPTH x DATA_W storage, one sync write port, one write-first sync read port.
// Rev 1.0 - initial release
`default_nettype none

module mram_resp_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] old_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Current contents at the write address, needed by transition-fault commits.
    assign old_data = mem[waddr];

    // Only the read register is reset; storage contents stay undefined until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
endmodule

`default_nettype wire

// File: rtl/mram_fault_responder.sv
// mram_fault_responder: MBIST-side MRAM model with write-recovery busy and one injectable bit fault.
// Rev 1.0 - initial release
`default_nettype none

module mram_fault_responder
    import mram_resp_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int WR_CYCLES = 4
) (
    input  logic                      bist_clk,
    input  logic                      bist_rst_l,
    mram_fault_responder_if.slave     bus,
    input  logic                      fault_en,
    input  fault_type_e               fault_type,
    input  logic [ADDR_W-1:0]         fault_addr,
    input  logic [$clog2(DATA_W)-1:0] fault_bit
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_CYCLES - 1);

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wrc_q;
    logic                   drop_q;
    logic                   rd_hit;
    fault_type_e            rd_type;
    logic [MAX_BIT_W-1:0]   rd_bit;

    logic                   commit, can_accept, wr_accept, rd_accept, wr_hit;
    logic [DATA_W-1:0]      old_word, commit_word, raw_rd;
    word_t                  old_ext, new_ext, rd_ext, commit_ext, rdf_ext;
    logic [MAX_BIT_W-1:0]   bit_ext;
    logic                   unused_hi;

    // The commit edge also accepts a new command, so the controller never loses a slot.
    assign commit     = (state == S_WBUSY) && (cnt == '0);
    assign can_accept = (state == S_IDLE) || commit;
    assign wr_accept  = can_accept && !bus.test_CEB && !bus.test_WEB;
    assign rd_accept  = can_accept && !bus.test_CEB && bus.test_WEB;
    assign wr_hit     = fault_en && (wr_addr == fault_addr);

    always_comb begin
        old_ext = '0;
        new_ext = '0;
        rd_ext  = '0;
        bit_ext = '0;
        old_ext[DATA_W-1:0] = old_word;
        new_ext[DATA_W-1:0] = wr_data;
        rd_ext[DATA_W-1:0]  = raw_rd;
        bit_ext[BIT_W-1:0]  = fault_bit;
    end

    assign commit_ext    = apply_write_fault(old_ext, new_ext, fault_type, bit_ext);
    assign commit_word   = wr_hit ? commit_ext[DATA_W-1:0] : wr_data;
    assign rdf_ext       = apply_read_fault(rd_ext, rd_type, rd_bit);
    assign bus.test_DOUT = rd_hit ? rdf_ext[DATA_W-1:0] : raw_rd;
    assign bus.WRC       = wrc_q;
    assign bus.cmd_drop  = drop_q;
    assign unused_hi     = ^{commit_ext, rdf_ext};

    mram_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (bist_clk),
        .rst_n    (bist_rst_l),
        .we       (commit),
        .waddr    (wr_addr),
        .wdata    (commit_word),
        .old_data (old_word),
        .re       (rd_accept),
        .raddr    (bus.test_A1),
        .rdata    (raw_rd)
    );

    always_ff @(posedge bist_clk or negedge bist_rst_l) begin
        if (!bist_rst_l) begin
            state   <= S_IDLE;
            cnt     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wrc_q   <= 1'b0;
            drop_q  <= 1'b0;
            rd_hit  <= 1'b0;
            rd_type <= FT_SA0;
            rd_bit  <= '0;
        end else begin
            case (state)
                S_WBUSY: begin
                    if (commit) begin
                        state <= S_IDLE;
                        wrc_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (!bus.test_CEB) drop_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (wr_accept) begin
                state   <= S_WBUSY;
                wrc_q   <= 1'b1;
                cnt     <= CNT_LOAD;
                wr_addr <= bus.test_A1;
                wr_data <= bus.test_DIN;
            end

            // Read-side fault is captured with the access so test_DOUT holds stable afterwards.
            if (rd_accept) begin
                rd_hit  <= fault_en && (bus.test_A1 == fault_addr);
                rd_type <= fault_type;
                rd_bit  <= bit_ext;
            end
        end
    end
endmodule

`default_nettype wire
